// File: rtl/button_event_decoder.sv
`timescale 1ns/1ps
// button_event_decoder: turns the debounced button level into one-cycle short,
// long and double press pulses, plus a wrapping event counter and last-event code.
module button_event_decoder #(
  parameter int LONG_CYCLES    = 50_000_000,
  parameter int DBL_GAP_CYCLES = 25_000_000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       clean_in,
  output logic       short_press,
  output logic       long_press,
  output logic       double_press,
  output logic [7:0] event_count,
  output logic [1:0] last_event,
  output logic       busy
);

  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam int GAP_W  = $clog2(DBL_GAP_CYCLES + 1);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES);
  localparam logic [GAP_W-1:0]  GAP_MAX  = GAP_W'(DBL_GAP_CYCLES);

  localparam logic [1:0] EV_SHORT  = 2'b01;
  localparam logic [1:0] EV_LONG   = 2'b10;
  localparam logic [1:0] EV_DOUBLE = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  state_t             state;
  logic               prev;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               rise;
  logic [HOLD_W-1:0]  hold_inc;
  logic [GAP_W-1:0]   gap_inc;

  assign rise = clean_in & ~prev;

  // Saturating increments: the transition out of the state fires at the
  // maximum, so the counters never need to wrap.
  assign hold_inc = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
  assign gap_inc  = (gap_cnt == GAP_MAX) ? gap_cnt : gap_cnt + 1'b1;

  // NOTE: every register here is assigned with <= so all state updates see the
  // values from before this edge, independent of statement order.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      prev         <= 1'b1;
      hold_cnt     <= '0;
      gap_cnt      <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      event_count  <= 8'd0;
      last_event   <= 2'b00;
      busy         <= 1'b0;
    end else begin
      prev         <= clean_in;
      // NOTE: pulses default low each cycle so any event is exactly one cycle wide.
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= PRESSED;
            hold_cnt <= HOLD_W'(1);
            busy     <= 1'b1;
          end
        end

        PRESSED: begin
          if (clean_in) begin
            hold_cnt <= hold_inc;
            if (hold_inc == HOLD_MAX) begin
              state       <= LONG_HELD;
              long_press  <= 1'b1;
              event_count <= event_count + 8'd1;
              last_event  <= EV_LONG;
            end
          end else begin
            state   <= WAIT_SECOND;
            gap_cnt <= GAP_W'(1);
          end
        end

        LONG_HELD: begin
          if (!clean_in) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        WAIT_SECOND: begin
          // Any high sample here is a rise, since this state is only held on lows.
          if (rise) begin
            state <= SECOND_PRESSED;
          end else if (!clean_in) begin
            gap_cnt <= gap_inc;
            if (gap_inc == GAP_MAX) begin
              state       <= IDLE;
              busy        <= 1'b0;
              short_press <= 1'b1;
              event_count <= event_count + 8'd1;
              last_event  <= EV_SHORT;
            end
          end
        end

        SECOND_PRESSED: begin
          if (!clean_in) begin
            state        <= IDLE;
            busy         <= 1'b0;
            double_press <= 1'b1;
            event_count  <= event_count + 8'd1;
            last_event   <= EV_DOUBLE;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
